// File: rtl/iic_eeprom_slave.sv
// I2C target emulating a 2-byte-addressed serial EEPROM with an internal byte RAM.
// SCL/SDA are oversampled on i_clk; SDA is driven open-drain (0 or z only).
module iic_eeprom_slave #(
  parameter logic [6:0]  P_DEVICE_ADDR = 7'b1010000,
  parameter int unsigned P_ADDR_WIDTH  = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_iic_scl,
  inout  wire                     io_iic_sda,
  output logic                    o_busy,
  output logic                    o_wr_valid,
  output logic [P_ADDR_WIDTH-1:0] o_wr_addr,
  output logic [7:0]              o_wr_data,
  output logic                    o_rd_valid,
  output logic [7:0]              o_rd_data
);

  localparam int unsigned DEPTH = 1 << P_ADDR_WIDTH;

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, ADDRH, ADDRH_ACK, ADDRL, ADDRL_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  state_t                  r_state, state_n;
  logic [2:0]              r_scl_sync, r_sda_sync;
  logic [2:0]              r_bit_cnt, bit_cnt_n;
  logic                    r_full, full_n;
  logic                    r_rw, rw_n;
  logic [6:0]              r_sh, sh_n;
  logic [7:0]              r_tx, tx_n;
  logic [7:0]              r_addr_h, addr_h_n;
  logic [P_ADDR_WIDTH-1:0] r_ptr, ptr_n, ptr_inc, rd_addr;
  logic                    r_sda_oe, sda_oe_n;
  logic                    busy_n, wr_valid_n, rd_valid_n;
  logic [P_ADDR_WIDTH-1:0] wr_addr_n;
  logic [7:0]              wr_data_n, rd_data_n, rx_byte, mem_rd;
  logic                    scl_s, scl_d, sda_s, sda_d;
  logic                    scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]              r_mem [DEPTH];

  assign io_iic_sda = r_sda_oe ? 1'b0 : 1'bz;

  assign scl_s     = r_scl_sync[1];
  assign scl_d     = r_scl_sync[2];
  assign sda_s     = r_sda_sync[1];
  assign sda_d     = r_sda_sync[2];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  assign rx_byte = {r_sh, sda_s};
  assign ptr_inc = r_ptr + P_ADDR_WIDTH'(1);
  // Only RDATA_ACK prefetches the next byte; every other load reads the current ptr.
  assign rd_addr = (r_state == RDATA_ACK) ? ptr_inc : r_ptr;
  assign mem_rd  = r_mem[rd_addr];

  always_comb begin
    state_n    = r_state;
    bit_cnt_n  = r_bit_cnt;
    full_n     = r_full;
    rw_n       = r_rw;
    sh_n       = r_sh;
    tx_n       = r_tx;
    addr_h_n   = r_addr_h;
    ptr_n      = r_ptr;
    sda_oe_n   = r_sda_oe;
    busy_n     = o_busy;
    wr_valid_n = 1'b0;
    wr_addr_n  = o_wr_addr;
    wr_data_n  = o_wr_data;
    rd_valid_n = 1'b0;
    rd_data_n  = o_rd_data;
    if (stop_det) begin
      state_n   = IDLE;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
      bit_cnt_n = '0;
      full_n    = 1'b0;
    end else if (start_det) begin
      state_n   = DEV;
      sda_oe_n  = 1'b0;
      bit_cnt_n = '0;
      full_n    = 1'b0;
    end else begin
      case (r_state)
        DEV, ADDRH, ADDRL, WDATA: begin
          // r_full marks "8 bits in, waiting for the fall that opens the ACK slot"
          if (scl_rise && !r_full) begin
            sh_n      = rx_byte[6:0];
            bit_cnt_n = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              full_n = 1'b1;
              case (r_state)
                DEV: begin
                  if (rx_byte[7:1] == P_DEVICE_ADDR) begin
                    busy_n = 1'b1;
                    rw_n   = rx_byte[0];
                  end else begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    full_n  = 1'b0;
                  end
                end
                ADDRH:   addr_h_n = rx_byte;
                ADDRL:   ptr_n = P_ADDR_WIDTH'({r_addr_h, rx_byte});
                default: begin
                  wr_valid_n = 1'b1;
                  wr_addr_n  = r_ptr;
                  wr_data_n  = rx_byte;
                  ptr_n      = ptr_inc;
                end
              endcase
            end
          end else if (scl_fall && r_full) begin
            full_n   = 1'b0;
            sda_oe_n = 1'b1;
            case (r_state)
              DEV: begin
                state_n = DEV_ACK;
                if (r_rw) begin
                  tx_n       = mem_rd;
                  rd_valid_n = 1'b1;
                  rd_data_n  = mem_rd;
                end
              end
              ADDRH:   state_n = ADDRH_ACK;
              ADDRL:   state_n = ADDRL_ACK;
              default: state_n = WDATA_ACK;
            endcase
          end
        end
        DEV_ACK, ADDRH_ACK, ADDRL_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
            case (r_state)
              DEV_ACK: begin
                if (r_rw) begin
                  state_n  = RDATA;
                  sda_oe_n = ~r_tx[7];
                end else begin
                  state_n = ADDRH;
                end
              end
              ADDRH_ACK: state_n = ADDRL;
              default:   state_n = WDATA;
            endcase
          end
        end
        RDATA: begin
          if (scl_rise && !r_full) begin
            bit_cnt_n = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) full_n = 1'b1;
          end else if (scl_fall) begin
            if (r_full) begin
              full_n   = 1'b0;
              sda_oe_n = 1'b0;
              state_n  = RDATA_ACK;
            end else begin
              tx_n     = {r_tx[6:0], 1'b0};
              sda_oe_n = ~r_tx[6];
            end
          end
        end
        RDATA_ACK: begin
          // here r_full means the master ACKed and the next byte is already loaded
          if (scl_rise && !r_full) begin
            if (sda_s) begin
              state_n = IDLE;
              busy_n  = 1'b0;
            end else begin
              ptr_n      = ptr_inc;
              tx_n       = mem_rd;
              rd_valid_n = 1'b1;
              rd_data_n  = mem_rd;
              full_n     = 1'b1;
            end
          end else if (scl_fall && r_full) begin
            full_n    = 1'b0;
            bit_cnt_n = '0;
            state_n   = RDATA;
            sda_oe_n  = ~r_tx[7];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_bit_cnt  <= '0;
      r_full     <= 1'b0;
      r_rw       <= 1'b0;
      r_sh       <= '0;
      r_tx       <= '0;
      r_addr_h   <= '0;
      r_ptr      <= '0;
      r_sda_oe   <= 1'b0;
      o_busy     <= 1'b0;
      o_wr_valid <= 1'b0;
      o_wr_addr  <= '0;
      o_wr_data  <= '0;
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
    end else begin
      r_state    <= state_n;
      r_scl_sync <= {r_scl_sync[1:0], i_iic_scl};
      r_sda_sync <= {r_sda_sync[1:0], io_iic_sda};
      r_bit_cnt  <= bit_cnt_n;
      r_full     <= full_n;
      r_rw       <= rw_n;
      r_sh       <= sh_n;
      r_tx       <= tx_n;
      r_addr_h   <= addr_h_n;
      r_ptr      <= ptr_n;
      r_sda_oe   <= sda_oe_n;
      o_busy     <= busy_n;
      o_wr_valid <= wr_valid_n;
      o_wr_addr  <= wr_addr_n;
      o_wr_data  <= wr_data_n;
      o_rd_valid <= rd_valid_n;
      o_rd_data  <= rd_data_n;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_valid_n && !i_rst) r_mem[wr_addr_n] <= wr_data_n;
  end

endmodule

// File: doc/iic_eeprom_slave.md
# iic_eeprom_slave

I2C target that emulates a 2-byte-addressed serial EEPROM. It is the responder counterpart to the team's I2C master drive block and serves as a synthesizable device model for loopback benches and FPGA self-test. It oversamples SCL/SDA on the system clock, decodes START/STOP, device and word-address bytes, writes bytes into an internal RAM, and serves sequential reads. SDA is driven open-drain.

## Interface
- P_DEVICE_ADDR, 7'b1010000, 7-bit device address this target answers to
- P_ADDR_WIDTH, 8, internal RAM address width; depth = 2^P_ADDR_WIDTH bytes, 1 ≤ P_ADDR_WIDTH ≤ 16
- i_clk  input  1  system clock; the only clock
- i_rst  input  1  reset, synchronous, active-high
- i_iic_scl  input  1  bus clock from the master, asynchronous to i_clk
- io_iic_sda  inout  1  bus data; the block drives only 0 or z
- o_busy  output  1  high from an address-matched START until STOP or a return to IDLE
- o_wr_valid  output  1  one-cycle pulse per byte committed to RAM
- o_wr_addr  output  P_ADDR_WIDTH  RAM address of the committed byte
- o_wr_data  output  8  committed byte
- o_rd_valid  output  1  one-cycle pulse per byte loaded for transmission
- o_rd_data  output  8  byte loaded for transmission

## Operation
- Input conditioning: SCL and SDA pass through 2-flop synchronizers plus one history flop. Rising/falling edges are detected on synchronized values. START = SDA falls while SCL high. STOP = SDA rises while SCL high.
- SDA pin: io_iic_sda = r_sda_oe ? 1'b0 : 1'bz. Input samples use the pin value.
- States: IDLE, DEV, DEV_ACK, ADDRH, ADDRH_ACK, ADDRL, ADDRL_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- START from any state goes to DEV (repeated START included) and clears the bit counter. STOP from any state goes to IDLE and releases SDA.
- Bits are sampled on SCL rising edges, MSB first. A 3-bit counter counts 8 bits, then one ACK slot.
- DEV, address mismatch: no ACK; go to IDLE; o_busy stays 0.
- DEV, match with R/W=0: ACK, then ADDRH.
- DEV, match with R/W=1: ACK, load mem[ptr], then RDATA.
- ADDRH / ADDRL: ACK each byte. ptr = {addr_h, addr_l}[P_ADDR_WIDTH-1:0]; unused high bits are ignored. After ADDRL_ACK, go to WDATA.
- WDATA: after the 8th bit, mem[ptr] <= byte, pulse o_wr_valid (o_wr_addr = ptr), then ptr <= ptr+1 with wrap at 2^P_ADDR_WIDTH. ACK, then WDATA again.
- RDATA: drive byte bits (0 → oe=1, 1 → release). After 8 bits, release SDA and sample the master's ACK on the 9th rising edge.
  - Master ACK (0): ptr+1 with wrap, load the next byte, continue in RDATA.
  - Master NACK (1): go to IDLE.
- ptr persists across transactions. A current-address read uses the last ptr.
- A STOP or START mid-byte discards the partial byte; no RAM write.
- RAM is not cleared by reset. Reset only clears control state.

## Timing
- Reset values: all outputs 0, r_sda_oe=0 (released), state IDLE, ptr=0.
- Bus requirement: SCL high and low phases each ≥ 4 i_clk cycles. SDA setup/hold around SCL edges ≥ 3 i_clk cycles.
- Detection latency: 2 cycles (synchronizer) plus 1 cycle (edge detect) after the pin edge.
- SDA changes (data bit, ACK assert, ACK release) are registered on the cycle after a detected SCL falling edge. They are therefore stable before the next SCL rise.
- ACK: oe asserts on the falling edge after the 8th bit and releases on the falling edge after the 9th.
- Write commit: o_wr_valid pulses the cycle after the 8th rising edge is detected. RAM is written the same cycle.
- Read load: the RAM read is registered, and o_rd_valid pulses on the load cycle. The first data bit is driven on the SCL falling edge that ends the ACK slot.
- Simultaneous events: START/STOP take priority over bit-edge processing in the same cycle.
- i_rst mid-transfer: SDA is released on the next cycle. Any held-low bus is freed.

## Test plan
- Write 0xA0 (dev 0x50, W), addr 0x0010, data 0x11,0x22,0x33, STOP → ACK on all 6 bytes; o_wr_valid ×3 at addrs 0x10/0x11/0x12.
- Random read: 0xA0, 0x0010, repeated START, 0xA1, read 3 bytes (ACK, ACK, NACK) → bus returns 0x11,0x22,0x33; state IDLE after NACK.
- Dev byte 0xA2 (0x51) → SDA stays high in the ACK slot; o_busy=0; no writes.
- Wrap: write addr 0x00FF with 0xAA,0xBB (P_ADDR_WIDTH=8) → mem[0xFF]=0xAA, mem[0x00]=0xBB.
- Abort: STOP after 5 bits of a WDATA byte → no o_wr_valid; next transaction decodes normally.
- Reset mid-read while driving 0 → SDA is z the cycle after i_rst; a subsequent write/read succeeds with ptr=0.
